// File: rtl/cmp_operand_issuer.sv
// Operand issuer for the compare-flag block: queues (a, b) pairs, drives them one at a
// time onto the block, samples its combinational flag output and returns it with a tag.
`timescale 1ns/1ps
module cmp_operand_issuer #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4,
    parameter int SEQW  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    output logic [WIDTH-1:0]         cmp_a,
    output logic [WIDTH-1:0]         cmp_b,
    input  logic [WIDTH-1:0]         cmp_c,
    output logic                     cmp_busy,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [WIDTH-1:0]         res_flag,
    output logic [SEQW-1:0]          res_seq,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // valid never depends on ready, and an offered result holds its data until taken.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] mem_a [DEPTH];
    logic [WIDTH-1:0] mem_b [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    logic fifo_empty;
    logic push;
    logic pop;
    logic handshake;

    assign fifo_empty = (fifo_count == '0);
    assign in_ready   = (fifo_count != CW'(DEPTH));
    assign push       = in_valid & in_ready & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Pops use the registered occupancy only, so a pair pushed this cycle waits one edge.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        handshake  = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = SAMPLE;
                end
            end
            SAMPLE: begin
                state_next = HOLD;
            end
            HOLD: begin
                if (res_ready) begin
                    handshake = 1'b1;
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        state_next = SAMPLE;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (flush) begin
            pop        = 1'b0;
            handshake  = 1'b0;
            state_next = IDLE;
        end
    end

    // Storage needs no reset: occupancy alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr] <= in_a;
            mem_b[wr_ptr] <= in_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            cmp_a      <= '0;
            cmp_b      <= '0;
            cmp_busy   <= 1'b0;
            res_valid  <= 1'b0;
            res_flag   <= '0;
            res_seq    <= '0;
        end else if (flush) begin
            // Flush drops queued and in-flight work but keeps the tag and last operands.
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            cmp_busy   <= 1'b0;
            res_valid  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
                cmp_a  <= mem_a[rd_ptr];
                cmp_b  <= mem_b[rd_ptr];
            end
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
            cmp_busy   <= pop;
            if (state == SAMPLE) begin
                res_flag  <= cmp_c;
                res_valid <= 1'b1;
            end else if (handshake) begin
                res_valid <= 1'b0;
                res_seq   <= res_seq + SEQW'(1);
            end
        end
    end

endmodule
